// File: rtl/grid_pwm_sched.sv
// Grid PWM scheduler: carrier up-counter, IDLE/RUN/FAULT FSM, one-deep duty buffer committed at the period wrap.
// Ready is combinational; an accepted request becomes visible at count 0 after the next wrap; backpressure holds while the buffer is full.
module grid_pwm_sched #(
  parameter logic [15:0] PERIOD_RST = 16'd2000
) (
  input  logic        sysclk,
  input  logic        global_rst,
  input  logic        enable,
  input  logic        fault,
  input  logic        fault_clr,
  input  logic [15:0] cfg_period,
  input  logic        cfg_load,
  input  logic        prot_valid,
  input  logic [15:0] prot_dm,
  input  logic [15:0] prot_sector,
  output logic        prot_ready,
  input  logic        ctrl_valid,
  input  logic [15:0] ctrl_dm,
  input  logic [15:0] ctrl_sector,
  output logic        ctrl_ready,
  output logic [15:0] global_cnt_rising,
  output logic [15:0] grid_dm,
  output logic [15:0] grid_sector,
  output logic        period_start,
  output logic [1:0]  state,
  output logic        sector_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_sh_q, period_sh_d;
  logic [15:0] period_nxt_q, period_nxt_d;
  logic [15:0] pend_dm_q, pend_dm_d;
  logic [15:0] pend_sector_q, pend_sector_d;
  logic        pend_full_q, pend_full_d;
  logic [15:0] grid_dm_q, grid_dm_d;
  logic [15:0] grid_sector_q, grid_sector_d;
  logic        sector_err_q, sector_err_d;

  logic        run, wrap, acc, sector_ok;
  logic [15:0] req_dm, req_sector;

  assign run        = (state_q == ST_RUN);
  assign wrap       = run && (cnt_q == period_sh_q - 16'd1);
  assign prot_ready = run && !pend_full_q;
  assign ctrl_ready = run && !pend_full_q && !prot_valid;
  assign acc        = (prot_valid && prot_ready) || (ctrl_valid && ctrl_ready);
  // ctrl can only be accepted when prot_valid is low, so prot_valid selects the source
  assign req_dm     = prot_valid ? prot_dm : ctrl_dm;
  assign req_sector = prot_valid ? prot_sector : ctrl_sector;
  assign sector_ok  = (req_sector >= 16'd1) && (req_sector <= 16'd6);

  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE:  if (enable)          state_d = ST_RUN;
        ST_RUN:   if (wrap && !enable) state_d = ST_IDLE;
        ST_FAULT: if (fault_clr)       state_d = ST_IDLE;
        default:                       state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    if (state_q == ST_IDLE || state_d == ST_IDLE || cnt_q >= period_sh_q - 16'd1) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    period_nxt_d = period_nxt_q;
    if (cfg_load) period_nxt_d = (cfg_period < 16'd2) ? 16'd2 : cfg_period;
    period_sh_d = (state_q == ST_IDLE || wrap) ? period_nxt_q : period_sh_q;

    sector_err_d = sector_err_q;
    if (fault_clr)              sector_err_d = 1'b0;
    else if (acc && !sector_ok) sector_err_d = 1'b1;

    pend_dm_d     = pend_dm_q;
    pend_sector_d = pend_sector_q;
    pend_full_d   = pend_full_q;
    grid_dm_d     = grid_dm_q;
    grid_sector_d = grid_sector_q;
    // leaving RUN drops any pending duty and parks the compare value high
    if (state_d != ST_RUN) begin
      pend_full_d = 1'b0;
      grid_dm_d   = 16'hFFFF;
    end else if (wrap && pend_full_q) begin
      grid_dm_d     = pend_dm_q;
      grid_sector_d = pend_sector_q;
      pend_full_d   = 1'b0;
    end else if (acc && sector_ok) begin
      pend_dm_d     = (req_dm > period_sh_q) ? period_sh_q : req_dm;
      pend_sector_d = req_sector;
      pend_full_d   = 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge global_rst) begin
    if (!global_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      period_sh_q   <= PERIOD_RST;
      period_nxt_q  <= PERIOD_RST;
      pend_dm_q     <= '0;
      pend_sector_q <= '0;
      pend_full_q   <= 1'b0;
      grid_dm_q     <= 16'hFFFF;
      grid_sector_q <= '0;
      sector_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_sh_q   <= period_sh_d;
      period_nxt_q  <= period_nxt_d;
      pend_dm_q     <= pend_dm_d;
      pend_sector_q <= pend_sector_d;
      pend_full_q   <= pend_full_d;
      grid_dm_q     <= grid_dm_d;
      grid_sector_q <= grid_sector_d;
      sector_err_q  <= sector_err_d;
    end
  end

  assign state             = state_q;
  assign global_cnt_rising = cnt_q;
  assign grid_dm           = grid_dm_q;
  assign grid_sector       = grid_sector_q;
  assign sector_err        = sector_err_q;
  assign period_start      = run && (cnt_q == 16'd0);

endmodule

// File: tb/tb_grid_pwm_sched.sv
// Randomized bench for grid_pwm_sched against a cycle-level behavioural model of the scheduler.
module tb_grid_pwm_sched;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_FAULT = 2;

  logic        sysclk = 1'b0;
  logic        global_rst = 1'b0;
  logic        enable = 1'b0;
  logic        fault = 1'b0;
  logic        fault_clr = 1'b0;
  logic [15:0] cfg_period = '0;
  logic        cfg_load = 1'b0;
  logic        prot_valid = 1'b0;
  logic [15:0] prot_dm = '0;
  logic [15:0] prot_sector = '0;
  logic        ctrl_valid = 1'b0;
  logic [15:0] ctrl_dm = '0;
  logic [15:0] ctrl_sector = '0;
  logic        prot_ready, ctrl_ready, period_start, sector_err;
  logic [15:0] global_cnt_rising, grid_dm, grid_sector;
  logic [1:0]  state;

  grid_pwm_sched #(.PERIOD_RST(16'd2000)) dut (
    .sysclk(sysclk), .global_rst(global_rst), .enable(enable), .fault(fault),
    .fault_clr(fault_clr), .cfg_period(cfg_period), .cfg_load(cfg_load),
    .prot_valid(prot_valid), .prot_dm(prot_dm), .prot_sector(prot_sector), .prot_ready(prot_ready),
    .ctrl_valid(ctrl_valid), .ctrl_dm(ctrl_dm), .ctrl_sector(ctrl_sector), .ctrl_ready(ctrl_ready),
    .global_cnt_rising(global_cnt_rising), .grid_dm(grid_dm), .grid_sector(grid_sector),
    .period_start(period_start), .state(state), .sector_err(sector_err)
  );

  always #5 sysclk = ~sysclk;

  typedef struct { int dm; int sec; } req_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   m_state, m_cnt, m_per_sh, m_per_nxt, m_dm, m_sec;
  bit   m_err;
  req_t pend_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_cnt = 0; m_per_sh = 2000; m_per_nxt = 2000;
    m_dm = 'hFFFF; m_sec = 0; m_err = 0;
    pend_q.delete();
  endtask

  task automatic check_all();
    bit rdy;
    rdy = (m_state == S_RUN) && (pend_q.size() == 0);
    chk("state", 32'(state), 32'(m_state));
    chk("counter", 32'(global_cnt_rising), 32'(m_cnt));
    chk("grid_dm", 32'(grid_dm), 32'(m_dm));
    chk("grid_sector", 32'(grid_sector), 32'(m_sec));
    chk("period_start", 32'(period_start), 32'(m_state == S_RUN && m_cnt == 0));
    chk("prot_ready", 32'(prot_ready), 32'(rdy));
    chk("ctrl_ready", 32'(ctrl_ready), 32'(rdy && !prot_valid));
    chk("sector_err", 32'(sector_err), 32'(m_err));
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int   ns, ncnt;
    bit   wrap, acc, ok;
    req_t r, c;
    if (!global_rst) begin
      model_reset();
      return;
    end
    wrap = (m_state == S_RUN) && (m_cnt == m_per_sh - 1);
    if (fault)                   ns = S_FAULT;
    else if (m_state == S_IDLE)  ns = enable ? S_RUN : S_IDLE;
    else if (m_state == S_RUN)   ns = (wrap && !enable) ? S_IDLE : S_RUN;
    else                         ns = fault_clr ? S_IDLE : S_FAULT;

    acc = 0; r.dm = 0; r.sec = 0;
    if (m_state == S_RUN && pend_q.size() == 0) begin
      if (prot_valid) begin acc = 1; r.dm = int'(prot_dm); r.sec = int'(prot_sector); end
      else if (ctrl_valid) begin acc = 1; r.dm = int'(ctrl_dm); r.sec = int'(ctrl_sector); end
    end
    if (r.dm > m_per_sh) r.dm = m_per_sh;
    ok = (r.sec >= 1) && (r.sec <= 6);

    ncnt = (m_state == S_IDLE || ns == S_IDLE) ? 0 : (m_cnt + 1) % m_per_sh;

    if (fault_clr)      m_err = 0;
    else if (acc && !ok) m_err = 1;

    if (ns != S_RUN) begin
      m_dm = 'hFFFF;
      pend_q.delete();
    end else begin
      if (wrap && pend_q.size() > 0) begin
        c = pend_q.pop_front();
        m_dm = c.dm; m_sec = c.sec;
      end
      if (acc && ok) pend_q.push_back(r);
    end

    if (m_state == S_IDLE || wrap) m_per_sh = m_per_nxt;
    if (cfg_load) m_per_nxt = (cfg_period < 16'd2) ? 2 : int'(cfg_period);
    m_state = ns;
    m_cnt = ncnt;
  endtask

  task automatic cycle();
    @(negedge sysclk);
    if (!global_rst) model_reset();
    check_all();
    model_step();
    @(posedge sysclk);
    #1;
  endtask

  int fault_hold = 0;

  initial begin
    model_reset();
    repeat (3) cycle();
    global_rst = 1'b1;
    repeat (2) cycle();
    cfg_load = 1'b1; cfg_period = 16'd10;
    cycle();
    cfg_load = 1'b0;
    repeat (2) cycle();
    enable = 1'b1;
    repeat (25) cycle();

    for (int i = 0; i < 3000; i++) begin
      prot_valid  = ($urandom_range(0, 99) < 20);
      ctrl_valid  = ($urandom_range(0, 99) < 45);
      prot_dm     = ($urandom_range(0, 99) < 10) ? 16'd50 : 16'($urandom_range(0, 12));
      ctrl_dm     = ($urandom_range(0, 99) < 10) ? 16'd50 : 16'($urandom_range(0, 12));
      prot_sector = ($urandom_range(0, 99) < 8) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(1, 6));
      ctrl_sector = ($urandom_range(0, 99) < 8) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(1, 6));
      cfg_load    = ($urandom_range(0, 99) < 3);
      cfg_period  = 16'($urandom_range(0, 12));
      enable      = ($urandom_range(0, 99) < 85);
      fault_clr   = ($urandom_range(0, 99) < 5);
      if (fault_hold == 0 && $urandom_range(0, 199) == 0) fault_hold = $urandom_range(1, 4);
      fault = (fault_hold > 0);
      if (fault_hold > 0) fault_hold--;
      if (i == 1500 || i == 1501) global_rst = 1'b0;
      else global_rst = 1'b1;
      if (i == 1502) begin
        cfg_load = 1'b1;
        cfg_period = 16'd8;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
